writeback_sq: RTL and testbench

WRITEBACK_SQ -- requirements
Module: writeback_sq

---
 rtl/writeback_sq_pkg.sv | 13 +
 rtl/writeback_sq_store_fifo.sv | 50 +++++
 rtl/writeback_sq.sv | 96 +++++++++
 tb/tb_writeback_sq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/writeback_sq_pkg.sv
// writeback_sq_pkg: shared register-file types, default widths and register indices.
// Exports regval_t/regfile_t (default-width register and register file),
// ZeroRegFile (all-zero register file) and the default parameter values used by writeback_sq.
package writeback_sq_pkg;
   localparam int DEF_W         = 32;
   localparam int DEF_NR        = 32;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_FLAGS_IDX = 30;
   localparam int DEF_PC_IDX    = 31;
   typedef logic [DEF_W-1:0] regval_t;
   typedef regval_t [DEF_NR-1:0] regfile_t;
   localparam regfile_t ZeroRegFile = '0;
endpackage

// File: rtl/writeback_sq_store_fifo.sv
// store_fifo: circular FIFO of {address, data} store entries.
// Ports: clock, reset_n (sync, active-low); push/in_addr/in_data enqueue;
// pop dequeues the head (ignored when empty); head_addr/head_data show the head entry;
// full, empty and count report occupancy. A pop frees a slot for a same-cycle push.
module store_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             in_addr,
   input  logic [W-1:0]             in_data,
   output logic [W-1:0]             head_addr,
   output logic [W-1:0]             head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] addr_q [DEPTH];
   logic [W-1:0] data_q [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   assign empty     = count == '0;
   assign full      = count == (AW+1)'(DEPTH);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clock) begin
      if (do_push) begin
         addr_q[wr_ptr] <= in_addr;
         data_q[wr_ptr] <= in_data;
      end
   end
endmodule

// File: rtl/writeback_sq.sv
// writeback_sq: writeback stage with register-file update, bypass feedback and a store queue.
// Ports: clock, reset_n (sync, active-low); execute inputs in_valid, dest_index, dest_value,
// upper_value, adjustment, has_upper, is_store, flushed_in, flags_in, pc_in, next_pc;
// hold stalls execute; input_registers/output_registers are the current/next register files;
// flushed_out toward fetch; mem_enable/mem_address/mem_data/mem_ack store port;
// fb_* bypass feedback; sq_count/sq_empty store-queue occupancy.
module writeback_sq
   import writeback_sq_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int NR        = DEF_NR,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int FLAGS_IDX = DEF_FLAGS_IDX,
   parameter int PC_IDX    = DEF_PC_IDX
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      hold,
   input  logic [$clog2(NR)-1:0]     dest_index,
   input  logic [W-1:0]              dest_value,
   input  logic [W-1:0]              upper_value,
   input  logic [W-1:0]              adjustment,
   input  logic                      has_upper,
   input  logic                      is_store,
   input  logic                      flushed_in,
   input  logic [3:0]                flags_in,
   input  logic [W-1:0]              pc_in,
   input  logic [W-1:0]              next_pc,
   input  logic [NR*W-1:0]           input_registers,
   output logic [NR*W-1:0]           output_registers,
   output logic                      flushed_out,
   output logic                      mem_enable,
   output logic [W-1:0]              mem_address,
   output logic [W-1:0]              mem_data,
   input  logic                      mem_ack,
   output logic                      fb_valid,
   output logic                      fb_has_upper,
   output logic [$clog2(NR)-1:0]     fb_index,
   output logic [W-1:0]              fb_value,
   output logic [W-1:0]              fb_upper,
   output logic [$clog2(DEPTH):0]    sq_count,
   output logic                      sq_empty
);
   logic [NR-1:0][W-1:0] in_regs, nxt_regs, regs;
   logic full, empty, accept, wr, push;
   logic [W-1:0] base;
   assign in_regs          = input_registers;
   assign output_registers = regs;
   // A full queue only stalls when no pop is freeing a slot this same cycle.
   assign hold     = reset_n && in_valid && is_store && full && !mem_ack;
   assign accept   = in_valid && !hold;
   assign wr       = accept && !is_store;
   assign push     = accept && is_store;
   assign base     = int'(dest_index) == PC_IDX ? pc_in : in_regs[dest_index];
   assign fb_valid     = in_valid && !is_store;
   assign fb_has_upper = has_upper;
   assign fb_index     = dest_index;
   assign fb_value     = dest_value;
   assign fb_upper     = upper_value;
   assign mem_enable   = !empty;
   assign sq_empty     = empty;
   // Later assignments win: flags merge, then result writes, then PC, then the hardwired zero.
   always_comb begin
      for (int i = 0; i < NR; i++) begin
         nxt_regs[i] = in_regs[i];
         if (i == FLAGS_IDX) nxt_regs[i][30:27] = flags_in;
         if (wr && i == int'(dest_index)) nxt_regs[i] = dest_value;
         if (wr && has_upper && i == int'(dest_index) + 1) nxt_regs[i] = upper_value;
      end
      nxt_regs[PC_IDX] = (wr && int'(dest_index) == PC_IDX) ? dest_value : next_pc;
      nxt_regs[0] = '0;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         regs        <= '0;
         flushed_out <= 1'b0;
      end else begin
         regs        <= nxt_regs;
         flushed_out <= accept ? flushed_in : 1'b0;
      end
   end
   store_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (mem_ack),
      .in_addr   (base + adjustment),
      .in_data   (dest_value),
      .head_addr (mem_address),
      .head_data (mem_data),
      .full      (full),
      .empty     (empty),
      .count     (sq_count)
   );
endmodule

// File: tb/tb_writeback_sq.sv
// tb_writeback_sq: directed stimulus with a store scoreboard checked by a separate monitor.
module tb_writeback_sq;
   import writeback_sq_pkg::*;
   logic clk = 0;
   logic reset_n, in_valid, hold, has_upper, is_store, flushed_in, flushed_out;
   logic [4:0] dest_index, fb_index;
   logic [31:0] dest_value, upper_value, adjustment, pc_in, next_pc, mem_address, mem_data, fb_value, fb_upper;
   logic [3:0] flags_in;
   logic [32*32-1:0] input_registers, output_registers;
   logic mem_enable, mem_ack, fb_valid, fb_has_upper, sq_empty;
   logic [2:0] sq_count;
   regfile_t in_regs;
   logic [63:0] exp_q[$];
   int total = 0, bad = 0;

   writeback_sq dut (
      .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .hold(hold),
      .dest_index(dest_index), .dest_value(dest_value), .upper_value(upper_value),
      .adjustment(adjustment), .has_upper(has_upper), .is_store(is_store),
      .flushed_in(flushed_in), .flags_in(flags_in), .pc_in(pc_in), .next_pc(next_pc),
      .input_registers(input_registers), .output_registers(output_registers),
      .flushed_out(flushed_out), .mem_enable(mem_enable), .mem_address(mem_address),
      .mem_data(mem_data), .mem_ack(mem_ack), .fb_valid(fb_valid), .fb_has_upper(fb_has_upper),
      .fb_index(fb_index), .fb_value(fb_value), .fb_upper(fb_upper),
      .sq_count(sq_count), .sq_empty(sq_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] r(input int i);
      return output_registers[i*32 +: 32];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one store; its expected memory transaction is queued only if it is accepted.
   task automatic store(input logic [4:0] idx, input logic [31:0] adj, input logic [31:0] data,
                        input logic [31:0] exp_addr);
      in_valid = 1; is_store = 1; dest_index = idx; adjustment = adj; dest_value = data;
      @(negedge clk);
      chk("fb_valid_store", {31'b0, fb_valid}, 0);
      if (!hold) exp_q.push_back({exp_addr, data});
      step();
      in_valid = 0; is_store = 0;
   endtask

   task automatic drain();
      int n = 0;
      mem_ack = 1;
      while (!sq_empty && n < 20) begin
         step();
         n++;
      end
      mem_ack = 0;
      chk("drain_empty", {31'b0, sq_empty}, 1);
   endtask

   // Monitor: whenever the DUT presents a store, it must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (reset_n && mem_enable) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_store: got addr %h data %h expected none", mem_address, mem_data);
            end else begin
               chk("mem_address", mem_address, exp_q[0][63:32]);
               chk("mem_data", mem_data, exp_q[0][31:0]);
               if (mem_ack) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) in_regs[i] = 32'h1000 + i;
      in_regs[3] = 32'h100;
      input_registers = in_regs;
      reset_n = 0; in_valid = 1; is_store = 1; has_upper = 0; flushed_in = 0; mem_ack = 0;
      dest_index = 0; dest_value = 0; upper_value = 0; adjustment = 0; flags_in = 0;
      pc_in = 32'h1FFC; next_pc = 32'h2000;
      step(); step();
      chk("hold_in_reset", {31'b0, hold}, 0);
      chk("reset_regs", {31'b0, output_registers == ZeroRegFile}, 1);
      chk("reset_count", {29'b0, sq_count}, 0);
      chk("reset_empty", {31'b0, sq_empty}, 1);
      chk("reset_mem_en", {31'b0, mem_enable}, 0);
      chk("reset_flushed", {31'b0, flushed_out}, 0);
      in_valid = 0; is_store = 0; reset_n = 1;
      // Non-store with upper half, flush marker and new flags
      in_valid = 1; dest_index = 5; dest_value = 32'h1234; has_upper = 1; upper_value = 32'hABCD;
      flushed_in = 1; flags_in = 4'b1010;
      #1;
      chk("fb_valid", {31'b0, fb_valid}, 1);
      chk("fb_index", {27'b0, fb_index}, 5);
      chk("fb_value", fb_value, 32'h1234);
      chk("fb_upper", fb_upper, 32'hABCD);
      chk("fb_has_upper", {31'b0, fb_has_upper}, 1);
      chk("hold_nonstore", {31'b0, hold}, 0);
      step();
      in_valid = 0; has_upper = 0; flushed_in = 0;
      chk("reg5", r(5), 32'h1234);
      chk("reg6_upper", r(6), 32'hABCD);
      chk("reg7_pass", r(7), 32'h1007);
      chk("flags_merge", r(30), 32'h5000_101E);
      chk("pc_next", r(31), 32'h2000);
      chk("flushed_out", {31'b0, flushed_out}, 1);
      // Register 0 is hardwired to zero
      in_valid = 1; dest_index = 0; dest_value = 32'hFFFF;
      step();
      chk("reg0_zero", r(0), 0);
      chk("flushed_clear", {31'b0, flushed_out}, 0);
      // Flags register as destination ignores flags_in
      dest_index = 30; dest_value = 32'h7;
      step();
      chk("flags_dest", r(30), 32'h7);
      // Upper write past the last register is dropped; PC takes the result
      dest_index = 31; dest_value = 32'h400; has_upper = 1; upper_value = 32'hDEAD;
      step();
      in_valid = 0; has_upper = 0;
      chk("pc_write", r(31), 32'h400);
      chk("reg0_after_wrap", r(0), 0);
      step();
      chk("pc_next_again", r(31), 32'h2000);
      // Ack with an empty queue is ignored
      mem_ack = 1;
      step();
      mem_ack = 0;
      chk("ack_empty_count", {29'b0, sq_count}, 0);
      // Two stores off base register 3, presented in order and held until acked
      store(3, 32'h4, 32'hA1, 32'h104);
      store(3, 32'h8, 32'hA2, 32'h108);
      chk("count2", {29'b0, sq_count}, 2);
      chk("pc_unchanged_by_store", r(31), 32'h2000);
      step(); step();
      drain();
      // Fill the queue, including PC-based and wrapping addresses
      store(3, 32'hFFFF_FFF0, 32'hB1, 32'hF0);
      store(31, 32'h10, 32'hB2, 32'h200C);
      store(3, 32'h20, 32'hB3, 32'h120);
      store(31, 32'h0, 32'hB4, 32'h1FFC);
      chk("count_full", {29'b0, sq_count}, 4);
      chk("mem_en_full", {31'b0, mem_enable}, 1);
      in_valid = 1; is_store = 0; dest_index = 9; dest_value = 32'h9;
      #1;
      chk("nonstore_no_hold_full", {31'b0, hold}, 0);
      in_valid = 1; is_store = 1; dest_index = 3; adjustment = 32'h40; dest_value = 32'hB5;
      @(negedge clk);
      chk("hold_full", {31'b0, hold}, 1);
      #1 mem_ack = 1;
      #1 chk("hold_released_by_ack", {31'b0, hold}, 0);
      exp_q.push_back({32'h140, 32'hB5});
      step();
      in_valid = 0; is_store = 0; mem_ack = 0;
      chk("count_push_pop", {29'b0, sq_count}, 4);
      drain();
      // Reset with a full queue discards pending stores and ignores a coincident ack
      store(3, 32'h1, 32'hC1, 32'h101);
      store(3, 32'h2, 32'hC2, 32'h102);
      store(3, 32'h3, 32'hC3, 32'h103);
      store(3, 32'h5, 32'hC4, 32'h105);
      reset_n = 0; in_valid = 1; is_store = 1; mem_ack = 0;
      #1 chk("hold_reset_full", {31'b0, hold}, 0);
      mem_ack = 1;
      step();
      exp_q.delete();
      reset_n = 1; in_valid = 0; is_store = 0; mem_ack = 0;
      chk("rst_empty", {31'b0, sq_empty}, 1);
      chk("rst_mem_en", {31'b0, mem_enable}, 0);
      chk("rst_count", {29'b0, sq_count}, 0);
      chk("rst_regs", {31'b0, output_registers == ZeroRegFile}, 1);
      step(); step();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
